// File: rtl/msp_trace_ctrl_pkg.sv
// Shared types and entry layout for the openMSP430 instruction-trace controller.
// Entry layout, MSB to LSB: {irq, pc[15:0], ir[15:0], cyc[CYC_W-1:0]}.
package msp_trace_ctrl_pkg;

    typedef enum logic [1:0] {
        TrcIdle  = 2'd0,
        TrcArmed = 2'd1,
        TrcPost  = 2'd2,
        TrcDone  = 2'd3
    } trc_state_e;

    localparam int unsigned ENTRY_FIXED_W = 33;

    function automatic int unsigned entry_w(input int unsigned cyc_w);
        return cyc_w + ENTRY_FIXED_W;
    endfunction

    function automatic int unsigned ir_lsb(input int unsigned cyc_w);
        return cyc_w;
    endfunction

    function automatic int unsigned pc_lsb(input int unsigned cyc_w);
        return cyc_w + 16;
    endfunction

    function automatic int unsigned irq_lsb(input int unsigned cyc_w);
        return cyc_w + 32;
    endfunction

endpackage

// File: rtl/msp_trace_ctrl_ram.sv
// Trace buffer storage: DEPTH x W array, one synchronous write port, one asynchronous read port.
module msp_trace_ctrl_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 41,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          mclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge mclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/msp_trace_ctrl.sv
// Instruction-trace capture controller: records one entry per decode into a circular buffer
// around a PC trigger, then drains the stored trace through a valid/ready read port.
module msp_trace_ctrl
    import msp_trace_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CYC_W  = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned EW    = CYC_W + 33
) (
    input  logic          mclk,
    input  logic          puc_rst_n,
    input  logic          decode,
    input  logic [15:0]   pc,
    input  logic [15:0]   ir,
    input  logic          irq_detect,
    input  logic          arm,
    input  logic          abort,
    input  logic          trig_en,
    input  logic [15:0]   trig_pc,
    input  logic [AW-1:0] post_cnt,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [EW-1:0] rd_data,
    output logic [1:0]    trc_state,
    output logic          trig_hit,
    output logic          overflow,
    output logic [AW:0]   count
);

    localparam int unsigned IR_LSB   = ir_lsb(CYC_W);
    localparam int unsigned PC_LSB   = pc_lsb(CYC_W);
    localparam int unsigned IRQ_LSB  = irq_lsb(CYC_W);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    trc_state_e      state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, post_q;
    logic [AW:0]     count_q;
    logic [CYC_W-1:0] cyc_q;
    logic            trig_hit_q, overflow_q;

    logic            capturing, wr_en, trig_match, arm_ok, full, pop;
    logic [EW-1:0]   wr_entry;

    assign capturing  = (state_q == TrcArmed) || (state_q == TrcPost);
    assign wr_en      = capturing && decode && !abort;
    assign trig_match = !trig_en || (pc == trig_pc);
    assign arm_ok     = arm && !abort && (state_q == TrcIdle);
    assign full       = (count_q == COUNT_FULL);
    assign pop        = rd_valid && rd_ready;

    always_comb begin
        wr_entry                       = '0;
        wr_entry[CYC_W-1:0]            = cyc_q;
        wr_entry[IR_LSB +: 16]         = ir;
        wr_entry[PC_LSB +: 16]         = pc;
        wr_entry[IRQ_LSB]              = irq_detect;
    end

    // State register
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            state_q <= TrcIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = TrcIdle;
        end else begin
            case (state_q)
                TrcIdle:  if (arm) state_d = TrcArmed;
                TrcArmed: if (decode && trig_match) begin
                    state_d = (post_cnt == '0) ? TrcDone : TrcPost;
                end
                TrcPost:  if (decode && (post_q == AW'(1))) state_d = TrcDone;
                TrcDone:  if (pop && (count_q == (AW + 1)'(1))) state_d = TrcIdle;
                default:  state_d = TrcIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        rd_valid  = (state_q == TrcDone) && (count_q != '0);
        trc_state = state_q;
        trig_hit  = trig_hit_q;
        overflow  = overflow_q;
        count     = count_q;
    end

    // Cycle-delta counter, saturating
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            cyc_q <= '0;
        end else if (decode || arm_ok) begin
            cyc_q <= '0;
        end else if (cyc_q != '1) begin
            cyc_q <= cyc_q + CYC_W'(1);
        end
    end

    // Pointers, occupancy, post-trigger counter and sticky flags
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_q     <= '0;
            trig_hit_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
        end else if (arm_ok) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_q     <= '0;
            trig_hit_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (full) begin
                // Oldest entry is overwritten; only pre-trigger loss counts as overflow
                rd_ptr_q <= rd_ptr_q + AW'(1);
                if (state_q == TrcArmed) begin
                    overflow_q <= 1'b1;
                end
            end else begin
                count_q <= count_q + (AW + 1)'(1);
            end
            if (state_q == TrcArmed && trig_match) begin
                trig_hit_q <= 1'b1;
                post_q     <= post_cnt;
            end else if (state_q == TrcPost) begin
                post_q <= post_q - AW'(1);
            end
        end else if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_q - (AW + 1)'(1);
        end
    end

    msp_trace_ctrl_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .mclk  (mclk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_msp_trace_ctrl.sv
// Self-checking bench for msp_trace_ctrl: table-driven capture vectors, scoreboard for readout,
// hand-written sequences for stall, abort and reset corner cases.
module tb_msp_trace_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CYC_W = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned EW    = CYC_W + 33;

    logic          mclk = 1'b0;
    logic          puc_rst_n;
    logic          decode, irq_detect, arm, abort, trig_en, rd_ready;
    logic [15:0]   pc, ir, trig_pc;
    logic [AW-1:0] post_cnt;
    logic          rd_valid, trig_hit, overflow;
    logic [EW-1:0] rd_data;
    logic [1:0]    trc_state;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] sb[$];

    typedef struct {
        int          gap;
        logic [15:0] pc;
        logic [15:0] ir;
        logic        irq;
        bit          cap;
        logic [1:0]  st;
        logic [AW:0] cnt;
    } vec_t;

    vec_t vt[5];

    msp_trace_ctrl #(
        .DEPTH (DEPTH),
        .CYC_W (CYC_W)
    ) dut (
        .mclk       (mclk),
        .puc_rst_n  (puc_rst_n),
        .decode     (decode),
        .pc         (pc),
        .ir         (ir),
        .irq_detect (irq_detect),
        .arm        (arm),
        .abort      (abort),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .post_cnt   (post_cnt),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .trc_state  (trc_state),
        .trig_hit   (trig_hit),
        .overflow   (overflow),
        .count      (count)
    );

    always #5 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // gap = idle cycles since previous decode or accepted arm
    task automatic dec(input int gap, input logic [15:0] p, input logic [15:0] i,
                       input logic q, input bit cap);
        logic [CYC_W-1:0] c;
        repeat (gap) tick();
        c = (gap > 255) ? 8'hFF : gap[7:0];
        decode = 1'b1; pc = p; ir = i; irq_detect = q;
        if (cap) begin
            if (sb.size() == DEPTH) sb.delete(0);
            sb.push_back({q, p, i, c});
        end
        tick();
        decode = 1'b0; irq_detect = 1'b0;
    endtask

    task automatic drain(input string nm);
        logic [EW-1:0] e;
        rd_ready = 1'b1;
        for (int k = 0; k < 40 && !(trc_state == 2'd0 && !rd_valid); k++) begin
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    check({nm, "_extra"}, 64'(rd_data), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check({nm, "_data"}, 64'(rd_data), 64'(e));
                end
            end
            tick();
        end
        rd_ready = 1'b0;
        check({nm, "_end_state"}, 64'(trc_state), 64'd0);
        check({nm, "_sb_left"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [EW-1:0] held, e;
        bit            stalled;
        int            xfers;
        bit            pat[5];

        puc_rst_n = 1'b0; decode = 1'b0; irq_detect = 1'b0; arm = 1'b0; abort = 1'b0;
        trig_en = 1'b0; rd_ready = 1'b0; pc = '0; ir = '0; trig_pc = '0; post_cnt = '0;
        repeat (3) tick();
        puc_rst_n = 1'b1;

        check("rst_state", 64'(trc_state), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_flags", 64'({trig_hit, overflow}), 64'd0);

        // Test 1: immediate trigger, post_cnt=3, fifth decode not captured
        vt[0] = '{0, 16'hF000, 16'h4031, 1'b0, 1'b1, 2'd2, 5'd1};
        vt[1] = '{0, 16'hF002, 16'h4032, 1'b0, 1'b1, 2'd2, 5'd2};
        vt[2] = '{0, 16'hF004, 16'h4033, 1'b0, 1'b1, 2'd2, 5'd3};
        vt[3] = '{0, 16'hF006, 16'h4034, 1'b0, 1'b1, 2'd3, 5'd4};
        vt[4] = '{0, 16'hF008, 16'h4035, 1'b0, 1'b0, 2'd3, 5'd4};
        trig_en = 1'b0; post_cnt = 4'd3;
        do_arm();
        check("t1_armed", 64'(trc_state), 64'd1);
        for (int v = 0; v < 5; v++) begin
            dec(vt[v].gap, vt[v].pc, vt[v].ir, vt[v].irq, vt[v].cap);
            check($sformatf("t1_state%0d", v), 64'(trc_state), 64'(vt[v].st));
            check($sformatf("t1_count%0d", v), 64'(count), 64'(vt[v].cnt));
        end
        check("t1_flags", 64'({trig_hit, overflow}), 64'b10);
        check("t1_valid", 64'(rd_valid), 64'd1);
        drain("t1");

        // Test 2: PC trigger after 20 pre-trigger decodes wraps the buffer
        trig_en = 1'b1; trig_pc = 16'hF100; post_cnt = 4'd2;
        do_arm();
        for (int n = 0; n < 20; n++) dec(0, 16'hE000 + 16'(2 * n), 16'(n), 1'b0, 1'b1);
        check("t2_armed", 64'(trc_state), 64'd1);
        check("t2_ovf_pre", 64'(overflow), 64'd1);
        check("t2_hit_pre", 64'(trig_hit), 64'd0);
        dec(0, 16'hF100, 16'hAAAA, 1'b0, 1'b1);
        check("t2_post", 64'(trc_state), 64'd2);
        dec(1, 16'hF102, 16'hBBBB, 1'b0, 1'b1);
        dec(0, 16'hF104, 16'hCCCC, 1'b0, 1'b1);
        check("t2_done", 64'(trc_state), 64'd3);
        check("t2_count", 64'(count), 64'd16);
        check("t2_flags", 64'({trig_hit, overflow}), 64'b11);
        drain("t2");

        // Test 3: cycle-delta field including saturation
        trig_en = 1'b0; post_cnt = 4'd2;
        do_arm();
        dec(1, 16'hC000, 16'h0001, 1'b0, 1'b1);
        dec(3, 16'hC002, 16'h0002, 1'b0, 1'b1);
        dec(300, 16'hC004, 16'h0003, 1'b0, 1'b1);
        check("t3_done", 64'(trc_state), 64'd3);
        drain("t3");

        // Test 4: back-pressure during readout
        trig_en = 1'b0; post_cnt = 4'd3;
        do_arm();
        for (int n = 0; n < 4; n++) dec(0, 16'hD000 + 16'(2 * n), 16'h5000 + 16'(n), 1'b0, 1'b1);
        check("t4_done", 64'(trc_state), 64'd3);
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        stalled = 1'b0; xfers = 0; held = '0;
        for (int k = 0; k < 5; k++) begin
            rd_ready = pat[k];
            check($sformatf("t4_valid%0d", k), 64'(rd_valid), 64'd1);
            if (!pat[k]) begin
                held = rd_data; stalled = 1'b1;
            end else begin
                if (stalled) check("t4_stable", 64'(rd_data), 64'(held));
                stalled = 1'b0;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check($sformatf("t4_data%0d", xfers), 64'(rd_data), 64'(e));
                end
                xfers++;
            end
            tick();
        end
        rd_ready = 1'b0;
        check("t4_idle", 64'(trc_state), 64'd0);
        check("t4_count", 64'(count), 64'd0);
        check("t4_valid_end", 64'(rd_valid), 64'd0);

        // Test 5: abort beats arm and decode during POST; later arm is clean
        trig_en = 1'b0; post_cnt = 4'd5;
        do_arm();
        dec(0, 16'hB000, 16'h1111, 1'b0, 1'b1);
        dec(0, 16'hB002, 16'h2222, 1'b0, 1'b1);
        check("t5_post", 64'(trc_state), 64'd2);
        abort = 1'b1; arm = 1'b1; decode = 1'b1; pc = 16'hB004;
        tick();
        abort = 1'b0; arm = 1'b0; decode = 1'b0;
        sb.delete();
        check("t5_abort_state", 64'(trc_state), 64'd0);
        check("t5_abort_count", 64'(count), 64'd0);
        check("t5_hit_held", 64'(trig_hit), 64'd1);
        do_arm();
        check("t5_rearm_state", 64'(trc_state), 64'd1);
        check("t5_rearm_hit", 64'(trig_hit), 64'd0);
        check("t5_rearm_count", 64'(count), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_armed", 64'(trc_state), 64'd0);

        // Test 6: IRQ entry with post_cnt=0, then reset during readout
        trig_en = 1'b0; post_cnt = 4'd0;
        do_arm();
        dec(2, 16'hFFFE, 16'h1234, 1'b1, 1'b1);
        check("t6_done", 64'(trc_state), 64'd3);
        check("t6_count", 64'(count), 64'd1);
        check("t6_valid", 64'(rd_valid), 64'd1);
        check("t6_irq", 64'(rd_data[EW-1]), 64'd1);
        check("t6_entry", 64'(rd_data), 64'(sb[0]));
        puc_rst_n = 1'b0; rd_ready = 1'b1;
        tick();
        puc_rst_n = 1'b1; rd_ready = 1'b0;
        sb.delete();
        check("t6_rst_state", 64'(trc_state), 64'd0);
        check("t6_rst_count", 64'(count), 64'd0);
        check("t6_rst_valid", 64'(rd_valid), 64'd0);
        check("t6_rst_flags", 64'({trig_hit, overflow}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
